occ_link_checker: RTL

OCC_LINK_CHECKER -- requirements
Module: occ_link_checker

---
 rtl/occ_link_checker_pkg.sv | 21 ++
 rtl/occ_link_checker_gen.sv | 47 ++++
 rtl/occ_link_checker.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/occ_link_checker_pkg.sv
// Shared definitions for the link checker: FSM state encoding and the
// default idle character used by both the TX generator and the RX checker.
package occ_link_checker_pkg;

    typedef enum logic [2:0] {
        ST_WAIT_RDY = 3'd0,
        ST_RESYNC   = 3'd1,
        ST_BLIND    = 3'd2,
        ST_CHECK    = 3'd3,
        ST_PASS     = 3'd4,
        ST_FAIL     = 3'd5
    } state_t;

    // 16-bit idle character and its K flags; wider links replicate these.
    localparam logic [15:0] IDLE_CHAR   = 16'h95bc;
    localparam logic [1:0]  IDLE_CHAR_K = 2'b01;

    // Error counter saturation value.
    localparam logic [7:0]  ERR_CNT_MAX = 8'hff;

endpackage

// File: rtl/occ_link_checker_gen.sv
// TX pattern generator: a free-running timestamp plus a phase counter.
// On phase 0 the current timestamp is sent as a data word (K=0); all other
// phases send the idle character. Output is registered (one-cycle latency).
module occ_link_checker_gen
    import occ_link_checker_pkg::*;
#(
    parameter int          g_DATA_WIDTH  = 16,
    parameter logic [15:0] g_IDLE        = IDLE_CHAR,
    parameter logic [1:0]  g_IDLE_K      = IDLE_CHAR_K,
    parameter int          g_IDLE_PERIOD = 13
) (
    input  logic                      clk,
    input  logic                      rst_n,
    output logic [g_DATA_WIDTH-1:0]   ts,
    output logic [g_DATA_WIDTH-1:0]   tx_data,
    output logic [g_DATA_WIDTH/8-1:0] tx_k
);

    localparam int KW = g_DATA_WIDTH / 8;
    localparam logic [g_DATA_WIDTH-1:0] IDLE_WORD   = {(g_DATA_WIDTH/16){g_IDLE}};
    localparam logic [KW-1:0]           IDLE_K_WORD = {(g_DATA_WIDTH/16){g_IDLE_K}};
    localparam logic [g_DATA_WIDTH-1:0] TS_STEP     = {{(g_DATA_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [7:0]              PHASE_LAST  = 8'(g_IDLE_PERIOD - 1);

    logic [7:0] phase;

    // Timestamp, phase counter and registered TX word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts      <= '0;
            phase   <= '0;
            tx_data <= IDLE_WORD;
            tx_k    <= IDLE_K_WORD;
        end else begin
            ts    <= ts + TS_STEP;
            phase <= (phase == PHASE_LAST) ? '0 : phase + 8'd1;
            if (phase == 8'd0) begin
                tx_data <= ts;
                tx_k    <= '0;
            end else begin
                tx_data <= IDLE_WORD;
                tx_k    <= IDLE_K_WORD;
            end
        end
    end

endmodule

// File: rtl/occ_link_checker.sv
// Link checker top: drives the TX test pattern and verifies the received
// stream (idle integrity, timestamp sequence, link status), tracking
// min/max loopback latency and declaring pass or fail.
module occ_link_checker
    import occ_link_checker_pkg::*;
#(
    parameter int          g_DATA_WIDTH         = 16,
    parameter logic [15:0] g_IDLE               = IDLE_CHAR,
    parameter logic [1:0]  g_IDLE_K             = IDLE_CHAR_K,
    parameter int          g_IDLE_PERIOD        = 13,
    parameter int          g_BLIND_PERIOD       = 10,
    parameter int          g_NUM_SUCCESFUL_DATA = 1000,
    parameter int          g_MAX_ERRORS         = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    output logic [g_DATA_WIDTH-1:0]   tx_data_o,
    output logic [g_DATA_WIDTH/8-1:0] tx_k_o,
    input  logic [g_DATA_WIDTH-1:0]   rx_data_i,
    input  logic [g_DATA_WIDTH/8-1:0] rx_k_i,
    input  logic                      rx_rdy_i,
    input  logic                      rx_remote_rdy_i,
    output logic                      rx_resync_o,
    input  logic                      rx_synced_i,
    input  logic                      rx_buf_err_i,
    output logic                      pass_o,
    output logic                      fail_o,
    output logic [7:0]                err_cnt_o,
    output logic [g_DATA_WIDTH-1:0]   latency_min_o,
    output logic [g_DATA_WIDTH-1:0]   latency_max_o
);

    localparam int KW = g_DATA_WIDTH / 8;
    localparam int GW = $clog2(g_NUM_SUCCESFUL_DATA + 1);
    localparam logic [g_DATA_WIDTH-1:0] IDLE_WORD   = {(g_DATA_WIDTH/16){g_IDLE}};
    localparam logic [KW-1:0]           IDLE_K_WORD = {(g_DATA_WIDTH/16){g_IDLE_K}};
    localparam logic [g_DATA_WIDTH-1:0] PERIOD_W    =
        {{(g_DATA_WIDTH-8){1'b0}}, 8'(g_IDLE_PERIOD)};
    localparam logic [15:0]             BLIND_LAST  = 16'(g_BLIND_PERIOD - 1);
    localparam logic [GW-1:0]           GOOD_LAST   = GW'(g_NUM_SUCCESFUL_DATA - 1);
    localparam logic [GW-1:0]           GOOD_ONE    = GW'(1);
    localparam logic [7:0]              MAX_ERR     = 8'(g_MAX_ERRORS);

    state_t                  state, state_next;
    logic [g_DATA_WIDTH-1:0] ts;
    logic [g_DATA_WIDTH-1:0] prev_data;
    logic                    have_prev;
    logic [15:0]             blind_cnt;
    logic [GW-1:0]           good_cnt;
    logic [7:0]              err_cnt;

    logic                    both_rdy;
    logic                    is_data;
    logic                    is_idle;
    logic                    seq_err;
    logic                    link_err;
    logic [g_DATA_WIDTH-1:0] seq_expect;
    logic [g_DATA_WIDTH-1:0] latency;
    logic [7:0]              err_next;

    occ_link_checker_gen #(
        .g_DATA_WIDTH (g_DATA_WIDTH),
        .g_IDLE       (g_IDLE),
        .g_IDLE_K     (g_IDLE_K),
        .g_IDLE_PERIOD(g_IDLE_PERIOD)
    ) u_gen (
        .clk    (clk_i),
        .rst_n  (rst_n_i),
        .ts     (ts),
        .tx_data(tx_data_o),
        .tx_k   (tx_k_o)
    );

    assign err_cnt_o = err_cnt;

    // Classify the received word; every error source folds into one flag so
    // coincident faults in a cycle count once.
    always_comb begin
        both_rdy   = rx_rdy_i & rx_remote_rdy_i;
        is_data    = (rx_k_i == '0);
        is_idle    = (rx_data_i == IDLE_WORD) && (rx_k_i == IDLE_K_WORD);
        seq_expect = prev_data + PERIOD_W;
        seq_err    = is_data && have_prev && (rx_data_i != seq_expect);
        link_err   = (!is_data && !is_idle) || seq_err || rx_buf_err_i ||
                     !rx_synced_i || !rx_rdy_i;
        latency    = ts - rx_data_i;
        err_next   = (err_cnt == ERR_CNT_MAX) ? err_cnt : err_cnt + 8'd1;
    end

    // FSM state register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state <= ST_WAIT_RDY;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state and status outputs.
    always_comb begin
        state_next  = state;
        rx_resync_o = 1'b0;
        pass_o      = 1'b0;
        fail_o      = 1'b0;
        case (state)
            ST_WAIT_RDY: begin
                if (both_rdy) state_next = ST_RESYNC;
            end
            ST_RESYNC: begin
                rx_resync_o = 1'b1;
                if (!both_rdy)        state_next = ST_WAIT_RDY;
                else if (rx_synced_i) state_next = ST_BLIND;
            end
            ST_BLIND: begin
                if (!both_rdy)                    state_next = ST_WAIT_RDY;
                else if (blind_cnt == BLIND_LAST) state_next = ST_CHECK;
            end
            ST_CHECK: begin
                if (link_err) begin
                    state_next = (err_next == MAX_ERR) ? ST_FAIL : ST_RESYNC;
                end else if (is_data && (good_cnt == GOOD_LAST)) begin
                    state_next = ST_PASS;
                end
            end
            ST_PASS: begin
                pass_o = 1'b1;
            end
            ST_FAIL: begin
                fail_o = 1'b1;
            end
            default: begin
                state_next = ST_WAIT_RDY;
            end
        endcase
    end

    // Blind-window counter, sequence tracking, error/good counters and
    // latency statistics. Latency is only folded in from error-free words.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            blind_cnt     <= '0;
            prev_data     <= '0;
            have_prev     <= 1'b0;
            good_cnt      <= '0;
            err_cnt       <= '0;
            latency_min_o <= '1;
            latency_max_o <= '0;
        end else begin
            case (state)
                ST_BLIND: begin
                    blind_cnt <= blind_cnt + 16'd1;
                    have_prev <= 1'b0;
                end
                ST_CHECK: begin
                    blind_cnt <= '0;
                    if (link_err) begin
                        err_cnt  <= err_next;
                        good_cnt <= '0;
                    end else if (is_data) begin
                        prev_data <= rx_data_i;
                        have_prev <= 1'b1;
                        good_cnt  <= good_cnt + GOOD_ONE;
                        if (latency < latency_min_o) latency_min_o <= latency;
                        if (latency > latency_max_o) latency_max_o <= latency;
                    end
                end
                default: begin
                    blind_cnt <= '0;
                end
            endcase
        end
    end

endmodule
